// File: rtl/fetch_unit.sv
// Instruction fetch stage. Keeps at most one read in flight to instruction
// memory and holds each returned word for decode. Handles flush and halt.
module fetch_unit #(
  parameter int PC_W    = 4,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PC_W-1:0]    pc_in,
  output logic               pc_en,
  input  logic               flush,
  input  logic               halt,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_out,
  output logic [PC_W-1:0]    instr_pc,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [PC_W-1:0] issued_pc;

  assign state_dbg = state;

  // Decode handshake: a word moves to decode on a cycle where instr_valid=1,
  // instr_ready=1 and flush=0. Once raised, instr_valid stays high, with
  // instr_out/instr_pc stable, until that transfer happens or a flush cancels it.
  always_comb begin
    state_nxt   = state;
    imem_req    = 1'b0;
    imem_addr   = pc_in;
    pc_en       = 1'b0;
    instr_valid = 1'b0;
    unique case (state)
      ISSUE: begin
        imem_req = rst_n && !halt && !flush;
        if (imem_req) state_nxt = WAIT;
      end
      WAIT: begin
        if (flush) begin
          state_nxt = imem_rvalid ? ISSUE : DRAIN;
        end else if (imem_rvalid) begin
          pc_en     = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        instr_valid = 1'b1;
        if (flush || instr_ready) state_nxt = ISSUE;
      end
      DRAIN: begin
        // The flushed read's data is dropped; flush here changes nothing.
        if (imem_rvalid) state_nxt = ISSUE;
      end
      default: state_nxt = ISSUE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ISSUE;
      issued_pc <= '0;
      instr_out <= '0;
      instr_pc  <= '0;
    end else begin
      state <= state_nxt;
      if (imem_req) issued_pc <= pc_in;
      // instr_pc comes from the address latched at issue, not the live pc_in.
      if (pc_en) begin
        instr_out <= imem_rdata;
        instr_pc  <= issued_pc;
      end
    end
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- PC_W, 4, program-counter and instruction-address width.
- INSTR_W, 16, instruction word width.

REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, the only clock.
- rst_n, in, 1, asynchronous active-low reset.
- pc_in, in, PC_W, current PC from the program-counter stage.
- pc_en, out, 1, one-cycle increment pulse to the program-counter stage.
- flush, in, 1, redirect; asserted in the same cycle as the program counter's load strobe.
- halt, in, 1, suppresses new fetch requests.
- imem_req, out, 1, single-cycle read strobe.
- imem_addr, out, PC_W, read address; meaningful only while imem_req=1.
- imem_rvalid, in, 1, read data valid; exactly one per accepted imem_req, 1 or more cycles after it.
- imem_rdata, in, INSTR_W, read data.
- instr_valid, out, 1, instruction available to decode.
- instr_ready, in, 1, decode accepts the instruction.
- instr_out, out, INSTR_W, fetched instruction.
- instr_pc, out, PC_W, address the instruction was fetched from.

REQ-003 The block SHALL use one clock (clk); reset is asynchronous and active-low (rst_n).

Function
REQ-004 The block SHALL implement four states: ISSUE, WAIT, HOLD, DRAIN.
REQ-005 imem_req SHALL be combinational: 1 iff state=ISSUE, halt=0, flush=0 and rst_n=1. imem_addr SHALL equal pc_in.
REQ-006 ISSUE transitions:
- imem_req=1 goes to WAIT.
- Otherwise the block SHALL stay in ISSUE.
REQ-007 WAIT, rvalid=1, flush=0:
- Register imem_rdata into instr_out.
- Register the issued address into instr_pc, latched at issue, not the live pc_in.
- Assert pc_en for exactly that cycle.
- Go to HOLD.
REQ-008 WAIT, rvalid=0, flush=0: the block SHALL stay in WAIT.
REQ-009 HOLD: instr_valid SHALL be 1. On instr_ready=1 with flush=0, the block SHALL go to ISSUE. Otherwise it SHALL stay in HOLD, with instr_out and instr_pc held stable.
REQ-010 instr_valid SHALL be 1 only in HOLD. Latency from accepted imem_req to instr_valid SHALL be the memory latency plus 1 cycle.
REQ-011 pc_en SHALL never be asserted outside the WAIT-capture cycle. It SHALL never be asserted when flush=1.
REQ-012 Flush in ISSUE: no request is issued; the block SHALL stay in ISSUE and request the new pc_in next cycle.
REQ-013 Flush in WAIT with rvalid=1: the data SHALL be discarded, pc_en=0, and the block SHALL go to ISSUE.
REQ-014 Flush in WAIT with rvalid=0: the block SHALL go to DRAIN.
REQ-015 DRAIN: the block SHALL issue no request and SHALL stay until rvalid=1. It SHALL then discard the data without pulsing pc_en and go to ISSUE. A further flush in DRAIN SHALL not change this behaviour.
REQ-016 Flush in HOLD, including when instr_ready=1 in the same cycle: the instruction SHALL be cancelled (no transfer) and the block SHALL go to ISSUE. instr_valid SHALL be 0 from the next cycle.
REQ-017 Priority: rst_n low > flush > halt > normal operation. halt SHALL affect only ISSUE.
REQ-018 At most one memory read SHALL be outstanding at any time.
REQ-019 PC wrap-around is owned by the program-counter stage. The block SHALL treat pc_in as an opaque PC_W-bit address with no range check.

Reset
REQ-020 While rst_n=0, the block SHALL hold:
- state = ISSUE.
- imem_req=0, pc_en=0, instr_valid=0.
- instr_out=0, instr_pc=0.
REQ-021 The first imem_req SHALL assert in the first clk edge window after rst_n deasserts, if halt=0.
REQ-022 Reset asserted mid-read SHALL abandon the outstanding read. A stale imem_rvalid arriving after reset release SHALL be treated as that of the first new request; the memory model is reset by the same rst_n.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Reset release, pc_in=0, rdata=16'hA5A5 with 1-cycle latency, instr_ready=1 -> imem_req at cycle 1, instr_valid at cycle 3 with instr_out=A5A5 and instr_pc=0, pc_en pulse at cycle 2, next imem_addr=1.
- instr_ready=0 for 5 cycles in HOLD -> instr_valid stays 1, instr_out/instr_pc stable, no new imem_req, single pc_en pulse.
- Flush during WAIT with 3-cycle latency, pc_in loaded to 4'h9 -> DRAIN, returned word discarded, no pc_en, next imem_addr=9.
- Flush coincident with instr_valid=1 and instr_ready=1 -> no transfer counted, instr_valid=0 next cycle, next request at the new pc_in.
- halt=1 in ISSUE for 4 cycles, then 0 -> imem_req=0 throughout the halt, then request at the unchanged pc_in.
- pc_in=4'hF fetch -> instr_pc=F, pc_en pulse, next imem_addr=0 (wrap).
